// File: rtl/gen_linear_pkg.sv
// Shared types and segment geometry for the streaming linear-part evaluator.
// Segment i (output bit i, or the carry-out when i == NBIT) covers n[seg_off(i) +: seg_len(i)].
package gen_linear_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    // Segment index 0 never owns n bits, so it doubles as "no owner".
    localparam int unsigned SEG_NONE = 0;

    function automatic int unsigned seg_len(input int unsigned i);
        return (32'd1 << (i + 1)) - 32'd1;
    endfunction

    function automatic int unsigned seg_off(input int unsigned i);
        return (32'd1 << (i + 1)) - i - 32'd3;
    endfunction

    function automatic int unsigned nnl(input int unsigned nbit, input int unsigned carry);
        if (carry != 0)
            return (32'd1 << (nbit + 2)) - nbit - 32'd4;
        else
            return (32'd1 << (nbit + 1)) - nbit - 32'd3;
    endfunction

    function automatic int unsigned nbeats(input int unsigned n, input int unsigned beat_w);
        return (n + beat_w - 32'd1) / beat_w;
    endfunction

    function automatic int unsigned seg_of(input int unsigned g, input int unsigned nbit,
                                           input int unsigned carry);
        int unsigned owner;
        int unsigned last;
        owner = SEG_NONE;
        last  = nbit - 32'd1 + carry;
        for (int unsigned i = 1; i <= last; i++) begin
            if (g >= seg_off(i) && g < seg_off(i) + seg_len(i))
                owner = i;
        end
        return owner;
    endfunction

endpackage

// File: rtl/gen_linear_seg_map.sv
// Folds one n beat into a per-segment parity vector; bit i is the XOR of the beat
// bits owned by segment i. Bit 0 is always 0 and bits at or above NNL fall into no segment.
module gen_linear_seg_map
    import gen_linear_pkg::*;
#(
    parameter int unsigned NBIT      = 7,
    parameter int unsigned CARRY_OUT = 0,
    parameter int unsigned BEAT_W    = 32,
    parameter int unsigned CW        = 3
) (
    input  logic [CW-1:0]             beat_idx,
    input  logic [BEAT_W-1:0]         n_data,
    output logic [NBIT+CARRY_OUT-1:0] par
);

    localparam int unsigned SEGW = NBIT + CARRY_OUT;

    int unsigned base;
    assign base = 32'(beat_idx) * BEAT_W;

    assign par[0] = 1'b0;

    for (genvar i = 1; i < SEGW; i++) begin : g_seg
        logic [BEAT_W-1:0] hit;
        for (genvar j = 0; j < BEAT_W; j++) begin : g_bit
            assign hit[j] = (seg_of(base + j, NBIT, CARRY_OUT) == i);
        end
        assign par[i] = ^(n_data & hit);
    end

endmodule

// File: rtl/gen_linear_stream.sv
// Streaming evaluator for the linear part of the generated adder: takes a/b/c_in, then
// NBEATS beats of the non-linear term vector n, and returns s (and optionally c_out).
module gen_linear_stream
    import gen_linear_pkg::*;
#(
    parameter int unsigned NBIT      = 7,
    parameter int unsigned CARRY_OUT = 0,
    parameter int unsigned BEAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [NBIT-1:0]   a,
    input  logic [NBIT-1:0]   b,
    input  logic              c_in,
    input  logic              n_valid,
    output logic              n_ready,
    input  logic [BEAT_W-1:0] n_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [NBIT-1:0]   s,
    output logic              c_out
);

    localparam int unsigned NNL       = nnl(NBIT, CARRY_OUT);
    localparam int unsigned NBEATS    = nbeats(NNL, BEAT_W);
    localparam int unsigned CW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned SEGW      = NBIT + CARRY_OUT;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    state_t state;
    state_t state_nxt;

    logic [NBIT-1:0] a_q;
    logic [NBIT-1:0] b_q;
    logic [SEGW-1:0] acc;
    logic [SEGW-1:0] acc_nxt;
    logic [SEGW-1:0] par;
    logic [CW-1:0]   beat_cnt;
    logic            op_fire;
    logic            n_fire;
    logic            last_beat;

    assign op_fire   = op_valid && op_ready;
    assign n_fire    = n_valid && n_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);

    gen_linear_seg_map #(
        .NBIT      (NBIT),
        .CARRY_OUT (CARRY_OUT),
        .BEAT_W    (BEAT_W),
        .CW        (CW)
    ) u_seg_map (
        .beat_idx (beat_cnt),
        .n_data   (n_data),
        .par      (par)
    );

    assign acc_nxt = acc ^ par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (op_valid)              state_nxt = ST_ACCUM;
            ST_ACCUM: if (n_valid && last_beat)  state_nxt = ST_DONE;
            ST_DONE:  if (s_ready)               state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready = 1'b0;
        n_ready  = 1'b0;
        s_valid  = 1'b0;
        unique case (state)
            ST_IDLE:  op_ready = 1'b1;
            ST_ACCUM: n_ready  = 1'b1;
            ST_DONE:  s_valid  = 1'b1;
            default:  op_ready = 1'b0;
        endcase
    end

    // Segment 0 owns no n bits, so its accumulator slot is seeded with c_in;
    // s then becomes a_q ^ b_q ^ acc uniformly across all bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            beat_cnt <= '0;
            s        <= '0;
        end else if (op_fire) begin
            a_q      <= a;
            b_q      <= b;
            acc      <= SEGW'(c_in);
            beat_cnt <= '0;
        end else if (n_fire) begin
            acc      <= acc_nxt;
            beat_cnt <= beat_cnt + CW'(1);
            if (last_beat)
                s <= a_q ^ b_q ^ acc_nxt[NBIT-1:0];
        end
    end

    if (CARRY_OUT != 0) begin : g_cout
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                c_out <= 1'b0;
            else if (n_fire && last_beat)
                c_out <= acc_nxt[NBIT];
        end
    end else begin : g_no_cout
        assign c_out = 1'b0;
    end

endmodule

// File: tb/tb_gen_linear_stream.sv
// Scoreboarded directed/random bench for gen_linear_stream in two configurations:
// NBIT=3/CARRY_OUT=1/BEAT_W=4 (NBEATS=7) and NBIT=7/CARRY_OUT=0/BEAT_W=32 (NBEATS=8).
module tb_gen_linear_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       op_valid3, op_ready3, c_in3, n_valid3, n_ready3, s_valid3, s_ready3, c_out3;
    logic [2:0] a3, b3, s3;
    logic [3:0] n_data3;

    logic        op_valid7, op_ready7, c_in7, n_valid7, n_ready7, s_valid7, s_ready7, c_out7;
    logic [6:0]  a7, b7, s7;
    logic [31:0] n_data7;

    gen_linear_stream #(.NBIT(3), .CARRY_OUT(1), .BEAT_W(4)) dut3 (
        .clk(clk), .rst(rst), .op_valid(op_valid3), .op_ready(op_ready3), .a(a3), .b(b3),
        .c_in(c_in3), .n_valid(n_valid3), .n_ready(n_ready3), .n_data(n_data3),
        .s_valid(s_valid3), .s_ready(s_ready3), .s(s3), .c_out(c_out3)
    );

    gen_linear_stream #(.NBIT(7), .CARRY_OUT(0), .BEAT_W(32)) dut7 (
        .clk(clk), .rst(rst), .op_valid(op_valid7), .op_ready(op_ready7), .a(a7), .b(b7),
        .c_in(c_in7), .n_valid(n_valid7), .n_ready(n_ready7), .n_data(n_data7),
        .s_valid(s_valid7), .s_ready(s_ready7), .s(s7), .c_out(c_out7)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] sbq[$];

    // Result packing: {c_out, s zero-extended to 8 bits}.
    function automatic logic [8:0] model(input int nbit, input int carry, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin,
                                         input logic [255:0] nv);
        logic [8:0] r;
        logic p;
        int off, len;
        r = '0;
        r[0] = a[0] ^ b[0] ^ cin;
        for (int i = 1; i < nbit + carry; i++) begin
            off = (1 << (i + 1)) - i - 3;
            len = (1 << (i + 1)) - 1;
            p = 1'b0;
            for (int g = off; g < off + len; g++) p ^= nv[g];
            if (i < nbit) r[i] = a[i] ^ b[i] ^ p;
            else          r[8] = p;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, o, e);
        end
    endtask

    function automatic logic op_rdy(input bit sel);
        return sel ? op_ready7 : op_ready3;
    endfunction
    function automatic logic n_rdy(input bit sel);
        return sel ? n_ready7 : n_ready3;
    endfunction
    function automatic logic s_vld(input bit sel);
        return sel ? s_valid7 : s_valid3;
    endfunction
    function automatic logic [8:0] obs(input bit sel);
        return sel ? {c_out7, 1'b0, s7} : {c_out3, 5'b0, s3};
    endfunction

    task automatic drive_op(input bit sel, input logic v, input logic [7:0] a, input logic [7:0] b,
                            input logic cin);
        if (sel) begin op_valid7 = v; a7 = a[6:0]; b7 = b[6:0]; c_in7 = cin; end
        else     begin op_valid3 = v; a3 = a[2:0]; b3 = b[2:0]; c_in3 = cin; end
    endtask

    task automatic drive_n(input bit sel, input logic v, input logic [31:0] d);
        if (sel) begin n_valid7 = v; n_data7 = d; end
        else     begin n_valid3 = v; n_data3 = d[3:0]; end
    endtask

    task automatic set_sready(input bit sel, input logic v);
        if (sel) s_ready7 = v; else s_ready3 = v;
    endtask

    task automatic send_op(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic cin);
        bit ok = 1'b0;
        @(negedge clk);
        drive_op(sel, 1'b1, a, b, cin);
        for (int t = 0; t < 20; t++) begin
            if (op_rdy(sel)) begin ok = 1'b1; @(posedge clk); break; end
            @(negedge clk);
        end
        chk("op_accept", 9'(ok), 9'd1);
    endtask

    task automatic send_beat(input bit sel, input logic [31:0] d, input bit gap, output logic early);
        bit ok = 1'b0;
        if (gap) begin
            @(negedge clk);
            drive_op(sel, 1'b0, 8'd0, 8'd0, 1'b0);
            drive_n(sel, 1'b0, '1);
            @(posedge clk);
        end
        @(negedge clk);
        drive_op(sel, 1'b0, 8'd0, 8'd0, 1'b0);
        drive_n(sel, 1'b1, d);
        early = s_vld(sel);
        for (int t = 0; t < 20; t++) begin
            if (n_rdy(sel)) begin ok = 1'b1; @(posedge clk); break; end
            @(negedge clk);
        end
        chk("n_accept", 9'(ok), 9'd1);
    endtask

    task automatic collect(input bit sel, input int hold);
        logic [8:0] e;
        @(negedge clk);
        drive_n(sel, 1'b0, 32'd0);
        e = '1;
        if (sbq.size() > 0) e = sbq.pop_front();
        chk("s_valid_latency", 9'(s_vld(sel)), 9'd1);
        chk("result", obs(sel), e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_result", obs(sel), e);
            chk("hold_s_valid", 9'(s_vld(sel)), 9'd1);
            chk("hold_op_ready", 9'(op_rdy(sel)), 9'd0);
            chk("hold_n_ready", 9'(n_rdy(sel)), 9'd0);
        end
        set_sready(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_sready(sel, 1'b0);
        chk("ret_op_ready", 9'(op_rdy(sel)), 9'd1);
        chk("ret_s_valid", 9'(s_vld(sel)), 9'd0);
        chk("kept_result", obs(sel), e);
    endtask

    task automatic run(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [255:0] nv, input bit gap, input int hold,
                       input logic [8:0] exp);
        int nb, bw;
        logic early, early_any;
        nb = sel ? 8 : 7;
        bw = sel ? 32 : 4;
        early_any = 1'b0;
        sbq.push_back(exp);
        send_op(sel, a, b, cin);
        for (int k = 0; k < nb; k++) begin
            send_beat(sel, nv[k*bw +: 32], gap, early);
            early_any |= early;
        end
        chk("s_valid_early", 9'(early_any), 9'd0);
        collect(sel, hold);
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic check_reset_outputs();
        chk("rst_op_ready3", 9'(op_ready3), 9'd1);
        chk("rst_n_ready3", 9'(n_ready3), 9'd0);
        chk("rst_s_valid3", 9'(s_valid3), 9'd0);
        chk("rst_result3", obs(1'b0), 9'd0);
        chk("rst_op_ready7", 9'(op_ready7), 9'd1);
        chk("rst_s_valid7", 9'(s_valid7), 9'd0);
        chk("rst_result7", obs(1'b1), 9'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] nv;
        logic [7:0] ra, rb;
        logic rc, early;

        rst = 1'b1;
        drive_op(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        drive_op(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        drive_n(1'b0, 1'b0, 32'd0);
        drive_n(1'b1, 1'b0, 32'd0);
        s_ready3 = 1'b0;
        s_ready7 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // All-zero beats: s = a^b^{..,c_in}, no carry-out.
        run(1'b0, 8'b101, 8'b011, 1'b1, '0, 1'b0, 0, 9'h007);

        // n[4] lies in segment 2.
        nv = '0; nv[4] = 1'b1;
        run(1'b0, 8'b101, 8'b011, 1'b1, nv, 1'b0, 0, 9'h003);

        // Beat 6 = 1111: n[24] is the top of the carry segment, n[25..27] are padding.
        nv = '0; nv[27:24] = 4'b1111;
        run(1'b0, 8'b101, 8'b011, 1'b1, nv, 1'b0, 5, 9'h107);

        // n_valid with junk while IDLE, then beats with idle cycles between them.
        @(negedge clk);
        drive_n(1'b0, 1'b1, 32'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_n_ready", 9'(n_ready3), 9'd0);
        end
        nv = '0; nv[4] = 1'b1;
        run(1'b0, 8'b101, 8'b011, 1'b1, nv, 1'b1, 0, 9'h003);

        for (int r = 0; r < 4; r++) begin
            nv = rand_vec(); ra = 8'($urandom()); rb = 8'($urandom()); rc = 1'($urandom());
            run(1'b0, ra, rb, rc, nv, r[0], 0, model(3, 1, ra, rb, rc, nv));
        end
        for (int r = 0; r < 3; r++) begin
            nv = rand_vec(); ra = 8'($urandom()); rb = 8'($urandom()); rc = 1'($urandom());
            run(1'b1, ra, rb, rc, nv, r[0], r, model(7, 0, ra, rb, rc, nv));
        end

        // Reset pulsed mid-transaction after three beats.
        send_op(1'b0, 8'b110, 8'b001, 1'b1);
        for (int k = 0; k < 3; k++) send_beat(1'b0, 32'($urandom()), 1'b0, early);
        @(negedge clk);
        drive_n(1'b0, 1'b0, 32'd0);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        nv = rand_vec(); ra = 8'($urandom()); rb = 8'($urandom()); rc = 1'($urandom());
        run(1'b0, ra, rb, rc, nv, 1'b0, 0, model(3, 1, ra, rb, rc, nv));
        for (int r = 0; r < 3; r++) begin
            nv = rand_vec(); ra = 8'($urandom()); rb = 8'($urandom()); rc = 1'($urandom());
            run(1'b1, ra, rb, rc, nv, r[1], 0, model(7, 0, ra, rb, rc, nv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
